// File: rtl/seq_checker.sv
// Receive-side checker for the repeating 8-byte pattern AF BC E2 78 FF E2 0B 8D.
// It acquires alignment, checks every valid byte while locked, and reports pulses and saturating counts.
module seq_checker #(
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [7:0]       data,
    output logic             locked,
    output logic [7:0]       expected,
    output logic             frame_ok,
    output logic             err,
    output logic             lost,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [7:0] SEQ_HEAD = 8'hAF;
    localparam logic [3:0] THRESH   = 4'(LOSS_THRESH);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t     state_reg;
    logic [2:0] pos_reg;
    logic [2:0] bad_run_reg;
    logic       frame_bad_reg;

    logic [2:0]       pos_inc;
    logic [7:0]       seq_cur;
    logic [7:0]       seq_inc;
    logic             byte_match;
    logic [3:0]       run_inc;
    logic             loss_hit;
    logic [CNT_W-1:0] frame_cnt_next;
    logic [CNT_W-1:0] err_cnt_next;

    function automatic logic [7:0] seq_at(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'hAF;
            3'd1:    return 8'hBC;
            3'd2:    return 8'hE2;
            3'd3:    return 8'h78;
            3'd4:    return 8'hFF;
            3'd5:    return 8'hE2;
            3'd6:    return 8'h0B;
            default: return 8'h8D;
        endcase
    endfunction

    // pos 7 wraps to 0, so the frame-end advance naturally points back at AF.
    assign pos_inc    = pos_reg + 3'd1;
    assign seq_cur    = seq_at(pos_reg);
    assign seq_inc    = seq_at(pos_inc);
    assign byte_match = (data == seq_cur);
    assign run_inc    = {1'b0, bad_run_reg} + 4'd1;
    assign loss_hit   = (run_inc == THRESH);

    assign frame_cnt_next = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
    assign err_cnt_next   = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= HUNT;
            pos_reg       <= 3'd0;
            bad_run_reg   <= 3'd0;
            frame_bad_reg <= 1'b0;
            locked        <= 1'b0;
            expected      <= SEQ_HEAD;
            frame_ok      <= 1'b0;
            err           <= 1'b0;
            lost          <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            frame_ok <= 1'b0;
            err      <= 1'b0;
            lost     <= 1'b0;
            if (valid) begin
                case (state_reg)
                    HUNT: begin
                        if (data == SEQ_HEAD) begin
                            state_reg <= SYNC;
                            pos_reg   <= 3'd1;
                            expected  <= seq_at(3'd1);
                        end
                    end
                    SYNC: begin
                        if (byte_match) begin
                            if (pos_reg == 3'd7) begin
                                state_reg <= LOCKED;
                                locked    <= 1'b1;
                                frame_ok  <= 1'b1;
                                frame_cnt <= frame_cnt_next;
                            end
                            pos_reg  <= pos_inc;
                            expected <= seq_inc;
                        end else if (data == SEQ_HEAD) begin
                            // AF appears only at index 0, so restarting here is exact.
                            pos_reg  <= 3'd1;
                            expected <= seq_at(3'd1);
                        end else begin
                            state_reg <= HUNT;
                            pos_reg   <= 3'd0;
                            expected  <= SEQ_HEAD;
                        end
                    end
                    LOCKED: begin
                        if (!byte_match && loss_hit) begin
                            state_reg     <= HUNT;
                            locked        <= 1'b0;
                            pos_reg       <= 3'd0;
                            expected      <= SEQ_HEAD;
                            lost          <= 1'b1;
                            err           <= 1'b1;
                            err_cnt       <= err_cnt_next;
                            bad_run_reg   <= 3'd0;
                            frame_bad_reg <= 1'b0;
                        end else begin
                            pos_reg  <= pos_inc;
                            expected <= seq_inc;
                            if (byte_match) begin
                                bad_run_reg <= 3'd0;
                            end else begin
                                err         <= 1'b1;
                                err_cnt     <= err_cnt_next;
                                bad_run_reg <= run_inc[2:0];
                            end
                            if (pos_reg == 3'd7) begin
                                if (byte_match && !frame_bad_reg) begin
                                    frame_ok  <= 1'b1;
                                    frame_cnt <= frame_cnt_next;
                                end
                                frame_bad_reg <= 1'b0;
                            end else if (!byte_match) begin
                                frame_bad_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= HUNT;
                        pos_reg   <= 3'd0;
                        expected  <= SEQ_HEAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: a pattern-level reference model predicts every cycle's outputs,
// and an independent monitor compares them one cycle later.
module tb_seq_checker;

    localparam int CNT_W       = 16;
    localparam int LOSS_THRESH = 2;
    localparam logic [7:0] PAT [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

    typedef struct packed {
        logic        locked;
        logic [7:0]  expected;
        logic        frame_ok;
        logic        err;
        logic        lost;
        logic [15:0] frame_cnt;
        logic [15:0] err_cnt;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             locked;
    logic [7:0]       expected;
    logic             frame_ok;
    logic             err;
    logic             lost;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    seq_checker #(.CNT_W(CNT_W), .LOSS_THRESH(LOSS_THRESH)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data(data),
        .locked(locked), .expected(expected), .frame_ok(frame_ok), .err(err), .lost(lost),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    obs_t sb [$];

    // Reference model: unlocked progress is the longest tail of the received bytes that is a
    // prefix of the pattern; locked progress is a byte index into the frame.
    logic [7:0] hist [$];
    bit m_locked;
    int m_k, m_idx, m_run, m_fcnt, m_ecnt;
    bit m_fbad, m_fok, m_err, m_lost;

    function automatic void model_reset();
        hist.delete();
        m_locked = 0; m_k = 0; m_idx = 0; m_run = 0; m_fbad = 0;
        m_fcnt = 0; m_ecnt = 0; m_fok = 0; m_err = 0; m_lost = 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    function automatic void model_step(input logic [7:0] d);
        if (!m_locked) begin
            int k;
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
            k = 0;
            for (int len = 1; len <= hist.size(); len++) begin
                bit ok;
                ok = 1;
                for (int j = 0; j < len; j++)
                    if (hist[hist.size() - len + j] != PAT[j]) ok = 0;
                if (ok) k = len;
            end
            if (k == 8) begin
                m_locked = 1; m_idx = 0; m_k = 0; hist.delete();
                m_fok = 1; m_fcnt = sat_inc(m_fcnt);
            end else begin
                m_k = k;
            end
        end else begin
            bit hit;
            hit = (d == PAT[m_idx]);
            if (!hit) begin
                m_err = 1; m_ecnt = sat_inc(m_ecnt); m_run++; m_fbad = 1;
                if (m_run >= LOSS_THRESH) begin
                    m_lost = 1; m_locked = 0; m_run = 0; m_fbad = 0; m_k = 0; hist.delete();
                    return;
                end
            end else begin
                m_run = 0;
            end
            if (m_idx == 7) begin
                if (!m_fbad) begin
                    m_fok = 1; m_fcnt = sat_inc(m_fcnt);
                end
                m_fbad = 0;
            end
            m_idx = (m_idx + 1) % 8;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.locked    = m_locked;
        o.expected  = m_locked ? PAT[m_idx] : PAT[m_k];
        o.frame_ok  = m_fok;
        o.err       = m_err;
        o.lost      = m_lost;
        o.frame_cnt = 16'(m_fcnt);
        o.err_cnt   = 16'(m_ecnt);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {locked, expected, frame_ok, err, lost, frame_cnt, err_cnt};
    endfunction

    function automatic void compare(input string tag, input obs_t act, input obs_t exp_o);
        n_checks++;
        if (act !== exp_o) begin
            n_fail++;
            $display("FAIL %s: got lock=%0b exp=%02h ok=%0b err=%0b lost=%0b fcnt=%0d ecnt=%0d, want lock=%0b exp=%02h ok=%0b err=%0b lost=%0b fcnt=%0d ecnt=%0d",
                     tag, act.locked, act.expected, act.frame_ok, act.err, act.lost, act.frame_cnt, act.err_cnt,
                     exp_o.locked, exp_o.expected, exp_o.frame_ok, exp_o.err, exp_o.lost, exp_o.frame_cnt, exp_o.err_cnt);
        end else begin
            $display("txn %0d %s: lock=%0b exp=%02h ok=%0b err=%0b lost=%0b fcnt=%0d ecnt=%0d",
                     n_txn, tag, act.locked, act.expected, act.frame_ok, act.err, act.lost, act.frame_cnt, act.err_cnt);
        end
    endfunction

    // Monitor: one prediction per clock, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                obs_t e;
                e = sb.pop_front();
                n_txn++;
                compare("cycle", dut_obs(), e);
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clk);
        rst   = 1'b0;
        valid = v;
        data  = d;
        m_fok = 0; m_err = 0; m_lost = 0;
        if (v) model_step(d);
        sb.push_back(model_obs());
    endtask

    task automatic send_frame();
        for (int i = 0; i < 8; i++) step(1'b1, PAT[i]);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        valid = 1'b0;
        model_reset();
        sb.push_back(model_obs());
        #2 rst = 1'b1;
        #1 compare("async_reset", dut_obs(), model_obs());
    endtask

    initial begin
        model_reset();
        repeat (2) begin
            @(negedge clk);
            sb.push_back(model_obs());
        end

        // Clean acquisition and two more frames
        send_frame();
        send_frame();
        send_frame();

        // Restart on AF after a loss
        step(1'b1, 8'h00); step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'hAF);
        send_frame();

        // Single error at index 5, then a clean frame
        for (int i = 0; i < 8; i++) step(1'b1, (i == 5) ? 8'hE3 : PAT[i]);
        send_frame();

        // Valid gaps with toggling data between index 3 and index 4
        for (int i = 0; i < 4; i++) step(1'b1, PAT[i]);
        for (int g = 0; g < 5; g++) step(1'b0, 8'($urandom));
        for (int i = 4; i < 8; i++) step(1'b1, PAT[i]);

        // Reset mid-frame at locked index 4, then a partial frame that must not lock
        for (int i = 0; i < 4; i++) step(1'b1, PAT[i]);
        mid_reset();
        for (int i = 4; i < 8; i++) step(1'b1, PAT[i]);
        send_frame();

        // Randomized frames with corruptions, slips and gaps
        for (int f = 0; f < 50; f++) begin
            if ($urandom_range(0, 9) == 0) step(1'b1, 8'($urandom));
            for (int i = 0; i < 8; i++) begin
                while ($urandom_range(0, 4) == 0) step(1'b0, 8'($urandom));
                if ($urandom_range(0, 11) == 0) step(1'b1, 8'($urandom));
                else step(1'b1, PAT[i]);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the 8-byte pattern stream emitted by `sequence_generator`. The pattern is AF, BC, E2, 78, FF, E2, 0B, 8D and repeats.
- Acquires alignment to the pattern, then checks every qualified byte against the expected value.
- Reports lock status, good-frame and error events, and saturating counts.
- Sits on the generator's `data` bus, in self-test and bring-up paths.

## Interface
- `CNT_W`, 16: width of `frame_cnt` and `err_cnt`.
- `LOSS_THRESH`, 2: consecutive mismatching bytes in LOCKED that drop lock; legal range 1..7.

Ports:
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `valid`  in  1: `data` carries a new pattern byte this cycle. Integration drives it from the generator `en` delayed one cycle, because `data` updates the cycle after `en`.
- `data`  in  8: received byte.
- `locked`  out  1: aligned to the pattern.
- `expected`  out  8: byte expected on the next valid cycle.
- `frame_ok`  out  1: one-cycle pulse when a frame completes in LOCKED with zero mismatches, or when SYNC completes.
- `err`  out  1: one-cycle pulse on each mismatching valid byte while LOCKED.
- `lost`  out  1: one-cycle pulse when lock is dropped.
- `frame_cnt`  out  `CNT_W`: count of `frame_ok` pulses; saturates at all-ones.
- `err_cnt`  out  `CNT_W`: count of `err` pulses; saturates at all-ones.

## Operation
- Pattern table: `SEQ[0..7]` = AF, BC, E2, 78, FF, E2, 0B, 8D.
- Registers:
  - `pos[2:0]`: index of the next expected byte.
  - `bad_run`: consecutive-mismatch count.
  - `frame_bad`: a mismatch has occurred in the current frame.
  - State: HUNT, SYNC or LOCKED.
- `expected` is always `SEQ[pos]`.
- Cycles with `valid`=0 change nothing; all pulse outputs are 0 on those cycles.
- HUNT (`pos`=0):
  - `data`==AF → SYNC, `pos`=1.
  - Otherwise stay in HUNT.
- SYNC:
  - `data`==`SEQ[pos]` with `pos`<7 → `pos`+1.
  - Match with `pos`==7 → LOCKED, `pos`=0, pulse `frame_ok`, increment `frame_cnt`.
  - Mismatch with `data`==AF → stay in SYNC, `pos`=1. AF occurs only at index 0, so this restart is exact.
  - Mismatch with any other byte → HUNT, `pos`=0.
  - No `err` pulses in SYNC or HUNT.
- LOCKED (`pos` advances modulo 8 on every valid byte, matched or not):
  - Match: `bad_run`=0.
  - Mismatch: pulse `err`, increment `err_cnt`, `bad_run`+1, set `frame_bad`.
  - Mismatch that makes `bad_run` reach `LOSS_THRESH`: → HUNT, `pos`=0, pulse `lost`, clear `bad_run` and `frame_bad`. This takes priority over the advance.
  - Byte at `pos`==7 without loss: pulse `frame_ok` and increment `frame_cnt` only if `frame_bad`=0 and this byte matched. `frame_bad` clears at frame end in either case.
- Counters hold at all-ones; no wrap.
- The duplicate E2 (indices 2 and 5) is resolved by `pos` only. No value-based realignment occurs in LOCKED.

## Timing
- All outputs are registered and update on the edge that samples the valid byte, so they are visible the following cycle.
- Reset values:
  - `locked`=0, `expected`=AF.
  - `frame_ok`, `err`, `lost` = 0.
  - `frame_cnt` and `err_cnt` = 0.
  - State HUNT, `pos`=0, `bad_run`=0, `frame_bad`=0.
- Reset asserted mid-frame forces the reset values asynchronously. No pulse is emitted.
- The first valid byte after reset deassertion is evaluated normally.
- `locked` rises together with the acquisition `frame_ok` pulse, and falls together with `lost`.
- Minimum acquisition is 8 valid bytes; `locked`=1 one cycle after the 8D is sampled.
- Back-to-back valid bytes are accepted every cycle; there is no backpressure.

## Test plan
- **Clean acquisition:** reset, then 8 back-to-back valid bytes AF..8D.
  - `locked`=1 and `frame_ok` pulses one cycle after 8D; `frame_cnt`=1.
  - Two more clean frames → `frame_cnt`=3, `err_cnt`=0.
- **Restart on AF:** stream 00, AF, AF, BC, E2, 78, FF, E2, 0B, 8D.
  - Lock follows the final 8D; no `err` pulses.
- **Single error while locked:** a frame carrying E3 at index 5.
  - One `err` pulse; `err_cnt`=1; `locked` stays 1.
  - No `frame_ok` for that frame; the next clean frame gives `frame_ok` and `frame_cnt`+1.
- **Loss of lock:** locked, then two consecutive bad bytes (00, 00) with `LOSS_THRESH`=2.
  - Two `err` pulses; `lost` pulses with the second; `locked`=0; `expected`=AF.
  - A clean frame then re-acquires.
- **Valid gaps:** `valid` low for 5 cycles between index 3 and index 4, with `data` toggling during the gap.
  - No state change and no pulses; the frame completes normally.
- **Reset mid-frame:** `rst` pulsed asynchronously between clock edges during LOCKED index 4.
  - All outputs return to reset values immediately.
  - Re-acquisition requires a full AF..8D.
